// File: rtl/target_pkg.sv
// Shared state encoding, slot record type and default screen geometry for the target frame sequencer.
package target_pkg;
  localparam int NUM_TARGETS_DEF   = 4;
  localparam int SCREEN_WIDTH_DEF  = 1280;
  localparam int SCREEN_HEIGHT_DEF = 720;
  localparam int XW = $clog2(SCREEN_WIDTH_DEF) + 1;
  localparam int YW = $clog2(SCREEN_HEIGHT_DEF) + 1;

  typedef enum logic [2:0] {IDLE, CAPTURE, SCAN, PRESENT, DONE} seq_state_t;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [YW-1:0] diam;
    logic          valid;
  } target_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/target_next_valid.sv
// Combinational priority finder: lowest set bit of elig_i whose index is >= start_i.
// Zero latency; a start pointer past the last slot simply reports nothing found.
module target_next_valid #(
  parameter int NUM_TARGETS = 4,
  parameter int IW          = 2
) (
  input  logic [NUM_TARGETS-1:0] elig_i,
  input  logic [IW:0]            start_i,
  output logic                   found_o,
  output logic [IW-1:0]          idx_o
);
  localparam int PW = IW + 1;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    // Walking downwards lets the lowest qualifying index win.
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (elig_i[i] && (PW'(i) >= start_i)) begin
        found_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
  end
endmodule

// File: rtl/target_frame_sequencer.sv
// Snapshots detector slots at frame end, clears the detector, streams eligible slots over valid/ready.
// First beat 3 cycles after frame_end, beat held under backpressure; TARGET_FILTER_EN adds a min-diameter filter.
module target_frame_sequencer
  import target_pkg::*;
#(
  parameter int NUM_TARGETS   = NUM_TARGETS_DEF,
  parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
`ifdef TARGET_FILTER_EN
  parameter int MIN_DIAMETER  = 4,
`endif
  localparam int PXW = $clog2(SCREEN_WIDTH) + 1,
  localparam int PYW = $clog2(SCREEN_HEIGHT) + 1,
  localparam int IW  = idx_width(NUM_TARGETS)
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic [PXW-1:0] hcount_in,
  input  logic [PYW-1:0] vcount_in,
  input  logic [PXW-1:0] det_x_in     [NUM_TARGETS],
  input  logic [PYW-1:0] det_y_in     [NUM_TARGETS],
  input  logic [PYW-1:0] det_diam_in  [NUM_TARGETS],
  input  logic           det_valid_in [NUM_TARGETS],
  output logic           det_clear_out,
  output logic [PXW-1:0] tgt_x_out,
  output logic [PYW-1:0] tgt_y_out,
  output logic [PYW-1:0] tgt_diam_out,
  output logic [IW-1:0]  tgt_idx_out,
  output logic           tgt_valid_out,
  input  logic           tgt_ready_in,
  output logic           frame_done_out,
  output logic [7:0]     drop_count_out
);
  localparam int PW = IW + 1;
  localparam logic [PYW-1:0] LAST_LINE = PYW'(SCREEN_HEIGHT);
`ifdef TARGET_FILTER_EN
  localparam logic [YW-1:0] MIN_DIAM = YW'(MIN_DIAMETER);
`endif

  seq_state_t           state_q, state_d;
  target_t              snap_q [NUM_TARGETS];
  target_t              snap_d [NUM_TARGETS];
  logic                 hit, hit_q, fe_q, clear_q;
  logic [7:0]           drop_q, drop_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PXW-1:0]       tx_q, tx_d;
  logic [PYW-1:0]       ty_q, ty_d, td_q, td_d;
  logic [IW-1:0]        tidx_q, tidx_d;
  logic                 tvld_q, tvld_d;
  logic [NUM_TARGETS-1:0] elig;
  logic                 found;
  logic [IW-1:0]        found_idx;

  assign hit = (hcount_in == '0) && (vcount_in == LAST_LINE);

  for (genvar i = 0; i < NUM_TARGETS; i++) begin : g_elig
`ifdef TARGET_FILTER_EN
    assign elig[i] = snap_q[i].valid && (snap_q[i].diam >= MIN_DIAM);
`else
    assign elig[i] = snap_q[i].valid;
`endif
  end

  // ptr_q always points one past the last presented slot, so during PRESENT the
  // finder already knows whether any beat remains and DONE follows the last transfer directly.
  target_next_valid #(.NUM_TARGETS(NUM_TARGETS), .IW(IW)) u_next_valid (
    .elig_i  (elig),
    .start_i (ptr_q),
    .found_o (found),
    .idx_o   (found_idx)
  );

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    ptr_d   = ptr_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    td_d    = td_q;
    tidx_d  = tidx_q;
    tvld_d  = tvld_q;
    drop_d  = drop_q;
    if (fe_q && (state_q != IDLE) && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    case (state_q)
      IDLE: if (fe_q) state_d = CAPTURE;
      CAPTURE: begin
        for (int i = 0; i < NUM_TARGETS; i++) begin
          snap_d[i].x     = det_x_in[i];
          snap_d[i].y     = det_y_in[i];
          snap_d[i].diam  = det_diam_in[i];
          snap_d[i].valid = det_valid_in[i];
        end
        ptr_d   = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if (found) begin
          tx_d    = snap_q[found_idx].x;
          ty_d    = snap_q[found_idx].y;
          td_d    = snap_q[found_idx].diam;
          tidx_d  = found_idx;
          tvld_d  = 1'b1;
          ptr_d   = PW'(found_idx) + PW'(1);
          state_d = PRESENT;
        end else begin
          state_d = DONE;
        end
      end
      PRESENT: begin
        if (tgt_ready_in) begin
          tvld_d  = 1'b0;
          state_d = found ? SCAN : DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      hit_q   <= 1'b0;
      fe_q    <= 1'b0;
      clear_q <= 1'b0;
      drop_q  <= '0;
      ptr_q   <= '0;
      tx_q    <= '0;
      ty_q    <= '0;
      td_q    <= '0;
      tidx_q  <= '0;
      tvld_q  <= 1'b0;
      for (int i = 0; i < NUM_TARGETS; i++) snap_q[i] <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit;
      fe_q    <= hit & ~hit_q;
      clear_q <= fe_q;
      drop_q  <= drop_d;
      ptr_q   <= ptr_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      td_q    <= td_d;
      tidx_q  <= tidx_d;
      tvld_q  <= tvld_d;
      snap_q  <= snap_d;
    end
  end

  assign det_clear_out  = clear_q;
  assign tgt_x_out      = tx_q;
  assign tgt_y_out      = ty_q;
  assign tgt_diam_out   = td_q;
  assign tgt_idx_out    = tidx_q;
  assign tgt_valid_out  = tvld_q;
  assign frame_done_out = (state_q == DONE);
  assign drop_count_out = drop_q;
endmodule

// File: tb/tb_target_frame_sequencer.sv
// Randomized bench: per-frame expected beat list built from the slot contents, compared cycle by cycle.
module tb_target_frame_sequencer;
  localparam int NT = 4;
  localparam int XW = 12;
  localparam int YW = 11;
  localparam int IW = 2;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [XW-1:0] hcount_in;
  logic [YW-1:0] vcount_in;
  logic [XW-1:0] det_x_in     [NT];
  logic [YW-1:0] det_y_in     [NT];
  logic [YW-1:0] det_diam_in  [NT];
  logic          det_valid_in [NT];
  logic          det_clear_out;
  logic [XW-1:0] tgt_x_out;
  logic [YW-1:0] tgt_y_out;
  logic [YW-1:0] tgt_diam_out;
  logic [IW-1:0] tgt_idx_out;
  logic          tgt_valid_out;
  logic          tgt_ready_in;
  logic          frame_done_out;
  logic [7:0]    drop_count_out;

  target_frame_sequencer dut (
    .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .det_x_in(det_x_in), .det_y_in(det_y_in), .det_diam_in(det_diam_in), .det_valid_in(det_valid_in),
    .det_clear_out(det_clear_out), .tgt_x_out(tgt_x_out), .tgt_y_out(tgt_y_out),
    .tgt_diam_out(tgt_diam_out), .tgt_idx_out(tgt_idx_out), .tgt_valid_out(tgt_valid_out),
    .tgt_ready_in(tgt_ready_in), .frame_done_out(frame_done_out), .drop_count_out(drop_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { int idx; int x; int y; int d; } beat_t;
  beat_t exp_q[$];
  int sx [NT];
  int sy [NT];
  int sd [NT];
  int sv [NT];
  int n_cmp = 0;
  int n_bad = 0;
  int exp_drop = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit eligible(input int v, input int d);
`ifdef TARGET_FILTER_EN
    return (v != 0) && (d >= 4);
`else
    return (v != 0) && (d >= 0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic park();
    hcount_in = XW'($urandom_range(1, 1279));
    vcount_in = YW'($urandom_range(0, 719));
  endtask

  task automatic scramble();
    for (int i = 0; i < NT; i++) begin
      det_x_in[i]     = XW'($urandom_range(0, 1279));
      det_y_in[i]     = YW'($urandom_range(0, 719));
      det_diam_in[i]  = YW'($urandom_range(0, 15));
      det_valid_in[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic rand_slots(input int dmin);
    for (int i = 0; i < NT; i++) begin
      sx[i] = $urandom_range(0, 1279);
      sy[i] = $urandom_range(0, 719);
      sd[i] = $urandom_range(dmin, 15);
      sv[i] = $urandom_range(0, 1);
    end
  endtask

  // Drives the slots and the frame_end condition, checks the clear pulse; ends 3 cycles after frame_end.
  task automatic launch_frame(input bit hold2);
    exp_q.delete();
    for (int i = 0; i < NT; i++) begin
      det_x_in[i]     = XW'(sx[i]);
      det_y_in[i]     = YW'(sy[i]);
      det_diam_in[i]  = YW'(sd[i]);
      det_valid_in[i] = (sv[i] != 0);
      if (eligible(sv[i], sd[i])) exp_q.push_back('{i, sx[i], sy[i], sd[i]});
    end
    hcount_in = '0;
    vcount_in = YW'(720);
    tick();
    if (!hold2) park();
    chk("clear_before_capture", 32'(det_clear_out), 0);
    tick();
    park();
    chk("clear_in_capture", 32'(det_clear_out), 1);
    tick();
    chk("clear_after_capture", 32'(det_clear_out), 0);
    scramble();
    tick();
  endtask

  task automatic stream_frame(input int mode, input bit inj);
    bit prev_xfer = 1'b0;
    bit fin = 1'b0;
    bit done_exp;
    int held = 0;
    int clears = 0;
    for (int c = 0; c < 400 && !fin; c++) begin
      done_exp = (exp_q.size() == 0) && (prev_xfer || c == 0);
      chk("frame_done", 32'(frame_done_out), 32'(done_exp));
      if (c == 0) chk("first_valid_latency", 32'(tgt_valid_out), 32'(exp_q.size() != 0));
      else if (prev_xfer) chk("valid_drop_after_xfer", 32'(tgt_valid_out), 0);
      if (det_clear_out) clears++;
      if (tgt_valid_out) begin
        if (exp_q.size() == 0) chk("extra_beat", 32'(tgt_valid_out), 0);
        else begin
          chk("beat_idx", 32'(tgt_idx_out), exp_q[0].idx);
          chk("beat_x", 32'(tgt_x_out), exp_q[0].x);
          chk("beat_y", 32'(tgt_y_out), exp_q[0].y);
          chk("beat_diam", 32'(tgt_diam_out), exp_q[0].d);
        end
      end
      fin = done_exp;
      case (mode)
        0:       tgt_ready_in = 1'($urandom_range(0, 1));
        1:       tgt_ready_in = 1'b1;
        default: tgt_ready_in = (held >= 10);
      endcase
      if (tgt_valid_out) held++;
      prev_xfer = tgt_valid_out && tgt_ready_in;
      if (prev_xfer && exp_q.size() != 0) void'(exp_q.pop_front());
      if (inj && c == 2) begin
        hcount_in = '0;
        vcount_in = YW'(720);
      end
      if (inj && c == 3) park();
      if (!fin) tick();
    end
    chk("stream_completed", 32'(fin), 1);
    chk("overrun_clear_count", clears, 32'(inj));
    chk("drop_count", 32'(drop_count_out), exp_drop);
    tick();
    chk("done_single_pulse", 32'(frame_done_out), 0);
    chk("idle_valid", 32'(tgt_valid_out), 0);
    tgt_ready_in = 1'($urandom_range(0, 1));
    repeat (2) tick();
  endtask

  initial begin
    rst_in = 1'b1;
    tgt_ready_in = 1'b0;
    park();
    scramble();
    repeat (3) tick();
    rst_in = 1'b0;
    tick();
    chk("rst_valid", 32'(tgt_valid_out), 0);
    chk("rst_x", 32'(tgt_x_out), 0);
    chk("rst_y", 32'(tgt_y_out), 0);
    chk("rst_diam", 32'(tgt_diam_out), 0);
    chk("rst_idx", 32'(tgt_idx_out), 0);
    chk("rst_clear", 32'(det_clear_out), 0);
    chk("rst_done", 32'(frame_done_out), 0);
    chk("rst_drop", 32'(drop_count_out), 0);

    // Valids 1,0,1,0 with ready held high.
    rand_slots(4);
    sv = '{1, 0, 1, 0};
    launch_frame(1'b0);
    stream_frame(1, 1'b0);

    // Empty frame.
    rand_slots(0);
    sv = '{0, 0, 0, 0};
    launch_frame(1'b0);
    stream_frame(0, 1'b0);

    // Backpressure: ready low for 10 valid cycles.
    rand_slots(0);
    sv[0] = 1;
    sd[0] = 9;
    launch_frame(1'b0);
    stream_frame(2, 1'b0);

    // Overrun while beats are pending.
    rand_slots(0);
    sv[0] = 1; sd[0] = 5;
    sv[3] = 1; sd[3] = 12;
    launch_frame(1'b0);
    exp_drop = 1;
    stream_frame(2, 1'b1);

    // Reset while a beat is being presented.
    rand_slots(4);
    sv = '{1, 1, 1, 1};
    launch_frame(1'b0);
    tgt_ready_in = 1'b0;
    repeat (2) tick();
    chk("pre_reset_valid", 32'(tgt_valid_out), 1);
    rst_in = 1'b1;
    #1;
    chk("reset_valid", 32'(tgt_valid_out), 0);
    chk("reset_drop", 32'(drop_count_out), 0);
    chk("reset_done", 32'(frame_done_out), 0);
    tick();
    rst_in = 1'b0;
    exp_drop = 0;
    repeat (2) tick();
    chk("post_reset_valid", 32'(tgt_valid_out), 0);
    rand_slots(4);
    sv = '{1, 1, 1, 1};
    launch_frame(1'b0);
    stream_frame(1, 1'b0);

    // Diameter boundary around the filter threshold.
    rand_slots(0);
    sv = '{1, 1, 1, 1};
    sd = '{3, 4, 10, 2};
    launch_frame(1'b0);
    stream_frame(1, 1'b0);

    for (int f = 0; f < 20; f++) begin
      rand_slots(0);
      launch_frame(1'($urandom_range(0, 1)));
      stream_frame(0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
